// File: rtl/ahb_sramc_pkg.sv
// Shared types and constants for the AHB-Lite SRAM slave.
//   htrans_e : AHB transfer types
//   hsize_e  : supported transfer sizes
//   hresp_e  : slave response codes
//   state_e  : slave control state
package ahb_sramc_pkg;

  localparam int NUM_LANES  = 4;
  localparam int NUM_GROUPS = 2;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'd0,
    HSIZE_HALF = 3'd1,
    HSIZE_WORD = 3'd2
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WR,
    ST_ERR1,
    ST_ERR2
  } state_e;

endpackage

// File: rtl/ahb_lane_decode.sv
// Combinational byte-lane decode for a 32-bit AHB transfer.
//   size    : hsize of the transfer
//   addr_lo : haddr[1:0]
//   lanes   : active byte lanes (zero when illegal)
//   illegal : unsupported size or misaligned address
module ahb_lane_decode
  import ahb_sramc_pkg::*;
(
  input  logic [2:0] size,
  input  logic [1:0] addr_lo,
  output logic [3:0] lanes,
  output logic       illegal
);

  always_comb begin
    lanes   = 4'b0000;
    illegal = 1'b0;
    case (size)
      HSIZE_BYTE: lanes = 4'b0001 << addr_lo;
      HSIZE_HALF: begin
        lanes   = addr_lo[1] ? 4'b1100 : 4'b0011;
        illegal = addr_lo[0];
      end
      HSIZE_WORD: begin
        lanes   = 4'b1111;
        illegal = (addr_lo != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
    if (illegal) lanes = 4'b0000;
  end

endmodule

// File: rtl/ahb_sram_slave.sv
// AHB-Lite slave in front of 8 single-port 8Kx8 SRAM banks (2 groups x 4 lanes).
//   hclk/hreset        : clock, synchronous active-high reset
//   hsel..hwdata       : AHB-Lite slave inputs
//   hready_resp/hresp  : slave ready and response
//   hrdata             : read data (zero outside a read data phase)
//   sram_ce/we/addr    : bank strobes, bank index = group*4 + lane
//   sram_wdata         : lane k feeds banks k and k+4
//   sram_rdata_g0/g1   : per-group read data, one cycle after the strobe
module ahb_sram_slave
  import ahb_sramc_pkg::*;
#(
  parameter int ADDR_WIDTH      = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int SRAM_ADDR_WIDTH = 13,
  parameter int SRAM_DATA_WIDTH = 8,
  parameter int HSIZE_WIDTH     = 3,
  parameter int HTRANS_WIDTH    = 2,
  parameter int HRESP_WIDTH     = 2
) (
  input  logic                       hclk,
  input  logic                       hreset,
  input  logic                       hsel,
  input  logic [ADDR_WIDTH-1:0]      haddr,
  input  logic [HTRANS_WIDTH-1:0]    htrans,
  input  logic [HSIZE_WIDTH-1:0]     hsize,
  input  logic [2:0]                 hburst,
  input  logic                       hwrite,
  input  logic                       hready,
  input  logic [DATA_WIDTH-1:0]      hwdata,
  output logic                       hready_resp,
  output logic [HRESP_WIDTH-1:0]     hresp,
  output logic [DATA_WIDTH-1:0]      hrdata,
  output logic [7:0]                 sram_ce,
  output logic                       sram_we,
  output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
  output logic [DATA_WIDTH-1:0]      sram_wdata,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_g0,
  input  logic [DATA_WIDTH-1:0]      sram_rdata_g1
);

  state_e                     state, state_nxt;
  logic                       rd_pend, rd_pend_nxt;
  logic                       rst_dly;
  logic                       cap_wr;
  logic                       decode_en;

  logic [3:0]                 wr_lanes_p1;
  logic                       wr_group_p1;
  logic [SRAM_ADDR_WIDTH-1:0] wr_word_p1;
  logic                       rd_group_p1;

  logic [3:0]                 lanes;
  logic                       illegal;
  logic [3:0]                 ce_lanes;
  logic                       ce_group;

  // Outputs stay quiet during reset and for one cycle after it.
  logic hold;
  assign hold = hreset | rst_dly;

  logic                       grp;
  logic [SRAM_ADDR_WIDTH-1:0] word;
  logic                       accept;
  logic                       rd_req;
  assign grp    = haddr[15];
  assign word   = haddr[2 +: SRAM_ADDR_WIDTH];
  assign accept = hsel & hready & htrans[1] & ~hold;
  // Read presented during a write data phase; independent of hready.
  assign rd_req = hsel & htrans[1] & ~hwrite;

  logic unused_bits;
  assign unused_bits = ^{haddr[ADDR_WIDTH-1:16], htrans[0], hburst};

  ahb_lane_decode u_lane_decode (
    .size    (hsize),
    .addr_lo (haddr[1:0]),
    .lanes   (lanes),
    .illegal (illegal)
  );

  always_ff @(posedge hclk) begin
    if (hreset) begin
      state   <= ST_IDLE;
      rd_pend <= 1'b0;
      rst_dly <= 1'b1;
    end else begin
      state   <= state_nxt;
      rd_pend <= rd_pend_nxt;
      rst_dly <= 1'b0;
    end
  end

  // Stage p1: address-phase info held for the following data phase.
  always_ff @(posedge hclk) begin
    if (cap_wr) begin
      wr_lanes_p1 <= lanes;
      wr_group_p1 <= grp;
      wr_word_p1  <= word;
    end
    if (rd_pend_nxt) rd_group_p1 <= grp;
  end

  always_comb begin
    state_nxt   = state;
    rd_pend_nxt = 1'b0;
    cap_wr      = 1'b0;
    decode_en   = 1'b0;
    ce_lanes    = 4'b0000;
    ce_group    = 1'b0;
    sram_we     = 1'b0;
    sram_addr   = '0;
    sram_wdata  = '0;
    hready_resp = 1'b1;
    hresp       = HRESP_OKAY;

    case (state)
      ST_IDLE: decode_en = 1'b1;
      ST_WR: begin
        ce_lanes  = wr_lanes_p1;
        ce_group  = wr_group_p1;
        sram_we   = 1'b1;
        sram_addr = wr_word_p1;
        for (int k = 0; k < NUM_LANES; k++)
          sram_wdata[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH] =
            hwdata[k*SRAM_DATA_WIDTH +: SRAM_DATA_WIDTH];
        state_nxt = ST_IDLE;
        if (rd_req) begin
          // Stall so the read is strobed only after this write lands.
          hready_resp = 1'b0;
        end else if (accept) begin
          if (illegal) begin
            state_nxt = ST_ERR1;
          end else if (hwrite) begin
            cap_wr    = 1'b1;
            state_nxt = ST_WR;
          end
        end
      end
      ST_ERR1: begin
        hready_resp = 1'b0;
        hresp       = HRESP_ERROR;
        state_nxt   = ST_ERR2;
      end
      ST_ERR2: begin
        hresp     = HRESP_ERROR;
        decode_en = 1'b1;
      end
      default: state_nxt = ST_IDLE;
    endcase

    if (decode_en) begin
      state_nxt = ST_IDLE;
      if (accept) begin
        if (illegal) begin
          state_nxt = ST_ERR1;
        end else if (hwrite) begin
          cap_wr    = 1'b1;
          state_nxt = ST_WR;
        end else begin
          ce_lanes    = lanes;
          ce_group    = grp;
          sram_addr   = word;
          rd_pend_nxt = 1'b1;
        end
      end
    end

    if (hold) begin
      ce_lanes    = 4'b0000;
      sram_we     = 1'b0;
      sram_addr   = '0;
      sram_wdata  = '0;
      hready_resp = 1'b1;
      hresp       = HRESP_OKAY;
    end

    sram_ce = ce_group ? {ce_lanes, 4'b0000} : {4'b0000, ce_lanes};
  end

  always_comb begin
    hrdata = '0;
    if (rd_pend && !hold) hrdata = rd_group_p1 ? sram_rdata_g1 : sram_rdata_g0;
  end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Self-checking bench for ahb_sram_slave: pipelined AHB master driven from a
// transfer table, behavioural SRAM banks, and a response scoreboard.
module tb_ahb_sram_slave;

  logic        hclk = 1'b0;
  logic        hreset;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [2:0]  hburst;
  logic        hwrite;
  logic        hready;
  logic [31:0] hwdata;
  logic        hready_resp;
  logic [1:0]  hresp;
  logic [31:0] hrdata;
  logic [7:0]  sram_ce;
  logic        sram_we;
  logic [12:0] sram_addr;
  logic [31:0] sram_wdata;
  logic [31:0] sram_rdata_g0;
  logic [31:0] sram_rdata_g1;

  always #5 hclk = ~hclk;

  ahb_sram_slave dut (
    .hclk          (hclk),
    .hreset        (hreset),
    .hsel          (hsel),
    .haddr         (haddr),
    .htrans        (htrans),
    .hsize         (hsize),
    .hburst        (hburst),
    .hwrite        (hwrite),
    .hready        (hready),
    .hwdata        (hwdata),
    .hready_resp   (hready_resp),
    .hresp         (hresp),
    .hrdata        (hrdata),
    .sram_ce       (sram_ce),
    .sram_we       (sram_we),
    .sram_addr     (sram_addr),
    .sram_wdata    (sram_wdata),
    .sram_rdata_g0 (sram_rdata_g0),
    .sram_rdata_g1 (sram_rdata_g1)
  );

  // SRAM banks; stored value is XORed with a pattern so the power-up
  // contents of bank b, address a read as {b[3:0], a[3:0]}.
  bit [7:0]  mem [8][8192];
  bit [7:0]  q   [8];
  int        we_cnt = 0;
  int        ce_cnt = 0;
  logic [7:0]  last_ce;
  logic [12:0] last_addr;
  logic [31:0] last_wdata;

  function automatic bit [7:0] pat(input int b, input logic [12:0] a);
    return 8'((b << 4) | int'(a[3:0]));
  endfunction

  always @(posedge hclk) begin
    for (int b = 0; b < 8; b++) begin
      if (sram_ce[b]) begin
        if (sram_we) mem[b][sram_addr] <= sram_wdata[8*(b%4) +: 8] ^ pat(b, sram_addr);
        else         q[b] <= mem[b][sram_addr] ^ pat(b, sram_addr);
      end
    end
    if (sram_we) begin
      we_cnt     <= we_cnt + 1;
      last_ce    <= sram_ce;
      last_addr  <= sram_addr;
      last_wdata <= sram_wdata;
    end
    if (sram_ce != 8'h00) ce_cnt <= ce_cnt + 1;
  end

  assign sram_rdata_g0 = {q[3], q[2], q[1], q[0]};
  assign sram_rdata_g1 = {q[7], q[6], q[5], q[4]};

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [1:0]  trans;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic [1:0]  exp_resp;
  } vec_t;

  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic [1:0]  resp;
  } exp_t;

  vec_t tbl [0:14];
  exp_t sbq [$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Applies table entries lo..hi back to back as a pipelined AHB master.
  task automatic run(input int lo, input int hi, output int stalls, output logic [1:0] stall_resp);
    int          idx;
    bit          have_d;
    logic        d_wr;
    logic [31:0] d_wdata;
    int          guard;
    exp_t        e;
    idx = lo; have_d = 0; d_wr = 0; d_wdata = 0; guard = 0;
    stalls = 0; stall_resp = 2'b00;
    while ((idx <= hi || have_d) && guard < 100) begin
      guard++;
      if (idx <= hi) begin
        hsel = 1'b1; htrans = tbl[idx].trans; haddr = tbl[idx].addr;
        hsize = tbl[idx].size; hwrite = tbl[idx].wr;
      end else begin
        hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0;
      end
      hwdata = (have_d && d_wr) ? d_wdata : 32'h0;
      @(negedge hclk);
      if (hready_resp) begin
        if (have_d) begin
          if (sbq.size() == 0) begin
            tests++; fails++;
            $display("FAIL scoreboard_empty: got 0 entries expected 1");
          end else begin
            e = sbq.pop_front();
            check($sformatf("hresp[%0d]", idx), {30'b0, hresp}, {30'b0, e.resp});
            if (!e.wr && e.resp == 2'b00)
              check($sformatf("hrdata[%0d]", idx), hrdata, e.rdata);
          end
        end
        if (idx <= hi) begin
          sbq.push_back('{tbl[idx].wr, tbl[idx].exp_rdata, tbl[idx].exp_resp});
          d_wr = tbl[idx].wr; d_wdata = tbl[idx].wdata; have_d = 1; idx++;
        end else begin
          have_d = 0;
        end
      end else begin
        stalls++;
        stall_resp = hresp;
      end
      hready = hready_resp;
      @(posedge hclk); #1;
    end
    if (guard >= 100) begin
      tests++; fails++;
      $display("FAIL run_timeout: got %0d cycles expected <100", guard);
    end
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h0; hready = 1'b1;
  endtask

  int         stalls;
  logic [1:0] sresp;
  int         we0, ce0;

  initial begin
    tbl[0]  = '{1'b1, 32'h0000_0010, 3'd2, 2'b10, 32'hDEADBEEF, 32'h0, 2'b00};
    tbl[1]  = '{1'b0, 32'h0000_0010, 3'd2, 2'b10, 32'h0, 32'hDEADBEEF, 2'b00};
    tbl[2]  = '{1'b1, 32'h0000_8003, 3'd0, 2'b10, 32'hAB00_0000, 32'h0, 2'b00};
    tbl[3]  = '{1'b0, 32'h0000_8000, 3'd2, 2'b10, 32'h0, 32'hAB60_5040, 2'b00};
    tbl[4]  = '{1'b1, 32'h0000_0100, 3'd2, 2'b10, 32'hC0DE_0000, 32'h0, 2'b00};
    tbl[5]  = '{1'b1, 32'h0000_0104, 3'd2, 2'b11, 32'hC0DE_0001, 32'h0, 2'b00};
    tbl[6]  = '{1'b1, 32'h0000_0108, 3'd2, 2'b11, 32'hC0DE_0002, 32'h0, 2'b00};
    tbl[7]  = '{1'b1, 32'h0000_010C, 3'd2, 2'b11, 32'hC0DE_0003, 32'h0, 2'b00};
    tbl[8]  = '{1'b0, 32'h0000_0100, 3'd2, 2'b10, 32'h0, 32'hC0DE_0000, 2'b00};
    tbl[9]  = '{1'b0, 32'h0000_0104, 3'd2, 2'b11, 32'h0, 32'hC0DE_0001, 2'b00};
    tbl[10] = '{1'b0, 32'h0000_0108, 3'd2, 2'b11, 32'h0, 32'hC0DE_0002, 2'b00};
    tbl[11] = '{1'b0, 32'h0000_010C, 3'd2, 2'b11, 32'h0, 32'hC0DE_0003, 2'b00};
    tbl[12] = '{1'b0, 32'h0000_0001, 3'd1, 2'b10, 32'h0, 32'h0, 2'b01};
    tbl[13] = '{1'b0, 32'h0000_0000, 3'd3, 2'b10, 32'h0, 32'h0, 2'b01};
    tbl[14] = '{1'b0, 32'h0000_0200, 3'd2, 2'b10, 32'h0, 32'h3020_1000, 2'b00};

    hreset = 1'b1; hsel = 1'b0; haddr = 32'h0; htrans = 2'b00; hsize = 3'd2;
    hburst = 3'b011; hwrite = 1'b0; hready = 1'b1; hwdata = 32'h0;

    for (int i = 0; i < 3; i++) begin
      @(negedge hclk);
      check($sformatf("rst_hready[%0d]", i), {31'b0, hready_resp}, 32'd1);
      check($sformatf("rst_hresp[%0d]", i), {30'b0, hresp}, 32'd0);
      check($sformatf("rst_ce[%0d]", i), {24'b0, sram_ce}, 32'd0);
      @(posedge hclk); #1;
    end
    hreset = 1'b0;
    @(negedge hclk);
    check("post_rst_ce", {24'b0, sram_ce}, 32'd0);
    check("post_rst_we", {31'b0, sram_we}, 32'd0);
    check("post_rst_addr", {19'b0, sram_addr}, 32'd0);
    check("post_rst_wdata", sram_wdata, 32'd0);
    check("post_rst_hrdata", hrdata, 32'd0);
    check("post_rst_hready", {31'b0, hready_resp}, 32'd1);
    @(posedge hclk); #1;

    // Word write then read-after-write.
    run(0, 1, stalls, sresp);
    check("raw_stalls", stalls, 32'd1);
    check("raw_wr_ce", {24'b0, last_ce}, 32'h0000_000F);
    check("raw_wr_addr", {19'b0, last_addr}, 32'd4);
    check("raw_wr_data", last_wdata, 32'hDEADBEEF);

    // Byte write in group 1, then word read.
    run(2, 3, stalls, sresp);
    check("byte_stalls", stalls, 32'd1);
    check("byte_wr_ce", {24'b0, last_ce}, 32'h0000_0080);
    check("byte_wr_addr", {19'b0, last_addr}, 32'd0);

    // 4-beat write burst then 4-beat read burst.
    we0 = we_cnt;
    run(4, 11, stalls, sresp);
    check("burst_stalls", stalls, 32'd1);
    check("burst_we_cnt", we_cnt - we0, 32'd4);
    check("burst_last_addr", {19'b0, last_addr}, 32'h43);

    // Illegal transfers.
    we0 = we_cnt; ce0 = ce_cnt;
    run(12, 13, stalls, sresp);
    check("err_stalls", stalls, 32'd2);
    check("err_stall_resp", {30'b0, sresp}, 32'd1);
    check("err_ce_cnt", ce_cnt - ce0, 32'd0);
    check("err_we_cnt", we_cnt - we0, 32'd0);

    // Reset during a write data phase drops the write.
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0200; hsize = 3'd2; hwrite = 1'b1;
    @(negedge hclk);
    check("wrst_accept_ready", {31'b0, hready_resp}, 32'd1);
    @(posedge hclk); #1;
    we0 = we_cnt;
    hsel = 1'b0; htrans = 2'b00; hwrite = 1'b0; hwdata = 32'h1234_5678; hreset = 1'b1;
    @(negedge hclk);
    check("wrst_we_in_rst", {31'b0, sram_we}, 32'd0);
    check("wrst_ce_in_rst", {24'b0, sram_ce}, 32'd0);
    @(posedge hclk); #1;
    hreset = 1'b0; hwdata = 32'h0;
    hsel = 1'b1; htrans = 2'b10; haddr = 32'h0000_0200; hsize = 3'd2; hwrite = 1'b0;
    @(negedge hclk);
    check("wrst_after_ce", {24'b0, sram_ce}, 32'd0);
    check("wrst_after_we", {31'b0, sram_we}, 32'd0);
    check("wrst_after_hready", {31'b0, hready_resp}, 32'd1);
    @(posedge hclk); #1;
    hsel = 1'b0; htrans = 2'b00;
    check("wrst_we_cnt", we_cnt - we0, 32'd0);
    run(14, 14, stalls, sresp);
    check("wrst_read_stalls", stalls, 32'd0);

    check("sb_empty", sbq.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ahb_sram_slave.md
Name: ahb_sram_slave

Overview:
- AHB-Lite slave that consumes the bus-side signal bundle (hsel, haddr, htrans, hsize, hburst, hwrite, hready, hwdata) and converts each transfer into strobes for 8 single-port synchronous SRAM banks, each 8K x 8.
- Banks are arranged as 2 groups x 4 byte lanes, giving 64 KB.
- Returns hrdata, hresp and hready_resp to the bus.
- Zero-wait reads and writes; one wait state only on a read immediately following a write.

Parameters:
- ADDR_WIDTH, 32, AHB address width.
- DATA_WIDTH, 32, AHB data width; fixed at 32, giving 4 byte lanes.
- SRAM_ADDR_WIDTH, 13, per-bank word address width.
- SRAM_DATA_WIDTH, 8, per-bank data width.
- HSIZE_WIDTH, 3, hsize width.
- HTRANS_WIDTH, 2, htrans width.
- HRESP_WIDTH, 2, hresp width.

Ports:
- hclk  in  1  clock; SRAM banks share it.
- hreset  in  1  synchronous, active-high reset.
- hsel  in  1  slave select.
- haddr  in  ADDR_WIDTH  address; bits [15:0] used.
- htrans  in  HTRANS_WIDTH  IDLE=00, BUSY=01, NONSEQ=10, SEQ=11.
- hsize  in  HSIZE_WIDTH  0=byte, 1=half, 2=word.
- hburst  in  3  ignored; each beat is handled independently.
- hwrite  in  1  1=write.
- hready  in  1  bus hready (previous data phase complete).
- hwdata  in  DATA_WIDTH  write data, valid in data phase.
- hready_resp  out  1  slave ready.
- hresp  out  HRESP_WIDTH  00=OKAY, 01=ERROR.
- hrdata  out  DATA_WIDTH  read data.
- sram_ce  out  8  per-bank chip enable, active-high; bank = group*4 + lane.
- sram_we  out  1  1=write, 0=read, common to all banks.
- sram_addr  out  SRAM_ADDR_WIDTH  common word address.
- sram_wdata  out  DATA_WIDTH  byte lane k drives banks k and k+4.
- sram_rdata_g0  in  DATA_WIDTH  group 0 read data, 1 cycle after read strobe.
- sram_rdata_g1  in  DATA_WIDTH  group 1 read data.

Behaviour:

Address decode and transfer acceptance:
- Accepted transfer = hsel & hready & htrans[1]. IDLE and BUSY get OKAY with zero wait and no SRAM access.
- Decode: group = haddr[15]; word = haddr[14:2].
- Byte lanes:
  - byte: lane haddr[1:0].
  - half: lanes {2*haddr[1], 2*haddr[1]+1}.
  - word: all 4 lanes.
- Illegal transfer (no SRAM access, ERROR response):
  - hsize > 2;
  - half with haddr[0] = 1;
  - word with haddr[1:0] != 0.

State machine (states IDLE, WR, ERR1, ERR2), plus a separate rd_pend flag with a registered rd_group:
- IDLE:
  - Accepted legal read: drive sram_ce (selected group, active lanes), sram_we=0, sram_addr=word combinationally in the address-phase cycle. Set rd_pend and register rd_group.
  - Accepted legal write: register group, lanes, word; go to WR.
  - Illegal transfer: go to ERR1.
- Read data phase (rd_pend=1): hrdata = group-selected sram_rdata, masked by nothing. Outside a read data phase hrdata = 0.
- WR (write data phase):
  - Drive registered ce lanes, sram_we=1, sram_addr=registered word, sram_wdata=hwdata.
  - If a read is presented in this cycle (hsel & htrans[1] & !hwrite): hready_resp=0 for one cycle; the write completes; the read is accepted in the next cycle. This guarantees read-after-write to the same address returns the new data.
  - Write followed by write: no stall. The new write is captured while the old write is performed.
  - Next state: WR if another write is accepted, ERR1 if illegal, else IDLE.
- ERR1: hready_resp=0, hresp=01, no SRAM strobes; go to ERR2.
- ERR2: hready_resp=1, hresp=01; then decode the new address phase as in IDLE.

Latency:
- Read: data valid in the cycle after address-phase acceptance (0 wait), or +1 cycle after a write.
- Write: SRAM written in the data-phase cycle.

Reset:
- While hreset=1 and in the first cycle after: sram_ce=0, sram_we=0, sram_addr=0, sram_wdata=0, hrdata=0, hready_resp=1, hresp=00.
- State returns to IDLE; rd_pend clears.
- A pending write at reset is dropped.

Decomposition:
- Package ahb_sramc_pkg holds:
  - htrans_e (IDLE/BUSY/NONSEQ/SEQ), hsize_e, hresp_e (OKAY/ERROR);
  - slave state enum;
  - NUM_LANES=4, NUM_GROUPS=2.
- One sub-module, ahb_lane_decode: combinational hsize/haddr[1:0] -> 4-bit lane mask plus illegal flag.

Test Plan:
- Reset then idle: hreset high 3 cycles, htrans=IDLE -> hready_resp=1, hresp=00, sram_ce=00000000 throughout.
- Word write then read at 0x0000_0010: write 0xDEADBEEF, read -> SRAM write with ce=00001111, addr=4. Read issues one stall cycle (hready_resp=0), then hrdata=0xDEADBEEF.
- Byte write at 0x0000_8003 with data 0xAB000000, then word read at 0x8000 -> ce=10000000 on write; read returns 0xAB in [31:24], other bytes unchanged.
- Back-to-back 4-beat INCR write burst at 0x100..0x10C, then back-to-back reads -> writes have zero wait states. One stall occurs at the write-to-read turnaround only. Reads return all four words with zero wait.
- Illegal transfers: half at 0x0001, then hsize=3 -> each gives a two-cycle ERROR (hready_resp 0 then 1, hresp=01) and no SRAM strobes.
- Reset asserted during WR state -> no sram_we in that cycle or the next cycle; subsequent read of that address returns the old contents.
